// File: rtl/video_mode_ctrl.sv
// Video mode switch sequencer: accepts mode requests, aligns the switch to a frame
// start, resets and blanks the timing generators, and acknowledges on the next frame.
module video_mode_ctrl #(
  parameter int NUM_MODES      = 4,
  parameter int DEFAULT_MODE   = 0,
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic       i_pixel_clk,
  input  logic       i_reset_n,
  input  logic       i_mode_req,
  input  logic [1:0] i_mode_sel,
  output logic       o_ready,
  output logic       o_mode_ack,
  input  logic       i_frame_start,
  output logic       o_timing_reset,
  output logic [1:0] o_mode,
  output logic       o_blank,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    RESET      = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  localparam int               HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [23:0]      WD_LAST    = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       MODE_LIMIT = 3'(NUM_MODES);
  localparam logic [1:0]       MODE_RST   = 2'(DEFAULT_MODE);

  state_t              state_q, state_nx;
  logic [1:0]          mode_q, mode_nx;
  logic [1:0]          pend_q, pend_nx;
  logic                ack_q, ack_nx;
  logic                timeout_q, timeout_nx;
  logic                boot_q, boot_nx;
  logic [23:0]         wd_q, wd_nx;
  logic [HOLD_W-1:0]   hold_q, hold_nx;

  logic sel_valid;
  logic wd_done;

  assign sel_valid = ({1'b0, i_mode_sel} < MODE_LIMIT);
  assign wd_done   = (wd_q == WD_LAST);

  // NOTE: every variable gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state_q;
    mode_nx    = mode_q;
    pend_nx    = pend_q;
    ack_nx     = 1'b0;
    timeout_nx = timeout_q;
    boot_nx    = boot_q;
    wd_nx      = wd_q;
    hold_nx    = hold_q;

    case (state_q)
      IDLE: begin
        if (i_mode_req) begin
          if (sel_valid && (i_mode_sel != mode_q)) begin
            pend_nx    = i_mode_sel;
            timeout_nx = 1'b0;
            wd_nx      = '0;
            state_nx   = WAIT_FRAME;
          end else begin
            ack_nx = 1'b1;
          end
        end
      end

      WAIT_FRAME: begin
        if (i_frame_start || wd_done) begin
          state_nx = RESET;
          mode_nx  = pend_q;
          hold_nx  = '0;
          if (!i_frame_start) timeout_nx = 1'b1;
        end else begin
          wd_nx = wd_q + 24'd1;
        end
      end

      // Frame starts are meaningless while the generators are held in reset.
      RESET: begin
        if (hold_q == HOLD_LAST) begin
          state_nx = RELEASE;
          wd_nx    = '0;
        end else begin
          hold_nx = hold_q + 1'b1;
        end
      end

      RELEASE: begin
        if (i_frame_start || wd_done) begin
          state_nx = IDLE;
          ack_nx   = !boot_q;
          boot_nx  = 1'b0;
          if (!i_frame_start) timeout_nx = 1'b1;
        end else begin
          wd_nx = wd_q + 24'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: reset puts the whole controller, not just the FSM, into a known state so
  // an in-flight switch is abandoned cleanly; boot_q suppresses the post-reset ack.
  always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= RESET;
      mode_q    <= MODE_RST;
      pend_q    <= MODE_RST;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      boot_q    <= 1'b1;
      wd_q      <= '0;
      hold_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same
      // pre-edge values, independent of statement order.
      state_q   <= state_nx;
      mode_q    <= mode_nx;
      pend_q    <= pend_nx;
      ack_q     <= ack_nx;
      timeout_q <= timeout_nx;
      boot_q    <= boot_nx;
      wd_q      <= wd_nx;
      hold_q    <= hold_nx;
    end
  end

  assign o_ready        = (state_q == IDLE);
  assign o_timing_reset = (state_q == RESET);
  assign o_blank        = (state_q == RESET) || (state_q == RELEASE);
  assign o_mode         = mode_q;
  assign o_mode_ack     = ack_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Scoreboard bench for video_mode_ctrl: the driver predicts each acknowledge from a
// transaction-level model, a monitor compares them; the driver also checks phase lengths.
module tb_video_mode_ctrl;

  localparam int NUM_MODES      = 4;
  localparam int DEFAULT_MODE   = 0;
  localparam int RESET_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int BOUND          = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_req = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       frame_start = 1'b0;
  logic       ready, mode_ack, timing_reset, blank, timeout;
  logic [1:0] mode;

  video_mode_ctrl #(
    .NUM_MODES     (NUM_MODES),
    .DEFAULT_MODE  (DEFAULT_MODE),
    .RESET_CYCLES  (RESET_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_pixel_clk   (clk),
    .i_reset_n     (rst_n),
    .i_mode_req    (mode_req),
    .i_mode_sel    (mode_sel),
    .o_ready       (ready),
    .o_mode_ack    (mode_ack),
    .i_frame_start (frame_start),
    .o_timing_reset(timing_reset),
    .o_mode        (mode),
    .o_blank       (blank),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int timeout;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   blank_bad = 0;
  int   model_mode = DEFAULT_MODE;
  int   model_timeout = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every acknowledge must match the oldest outstanding prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && timing_reset && !blank) blank_bad++;
    if (rst_n && mode_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        check("ack_mode", int'(mode), e.mode);
        check("ack_timeout", int'(timeout), e.timeout);
      end
    end
  end

  // Releases reset and walks the boot sequence; a frame start is given on the
  // rel_pulse-th clock of RELEASE.
  task automatic do_boot(input int rel_pulse);
    int n;
    rst_n = 1'b1;
    #1;
    n = 0;
    while (timing_reset === 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check("boot_hold_len", n, RESET_CYCLES);
    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin
      n++;
      if (n == 1) check("boot_release_blank", int'(blank), 1);
      frame_start = (n == rel_pulse);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("boot_release_len", n, rel_pulse);
    check("boot_no_ack", int'(mode_ack), 0);
    check("boot_mode", int'(mode), DEFAULT_MODE);
    check("boot_blank_off", int'(blank), 0);
    model_mode    = DEFAULT_MODE;
    model_timeout = 0;
  endtask

  // One request. wait_pulse/rel_pulse = 0 means no frame start, so the watchdog fires.
  task automatic do_request(input int sel, input int wait_pulse, input int rel_pulse,
                            input bit coincident, input bit inject);
    int   n;
    bit   is_sw;
    bit   wait_to, rel_to;
    exp_t e;
    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    if (n >= BOUND) check("ready_wait", 0, 1);

    is_sw   = (sel < NUM_MODES) && (sel != model_mode);
    wait_to = (wait_pulse == 0);
    rel_to  = (rel_pulse == 0);
    if (is_sw) begin
      model_mode    = sel;
      model_timeout = (wait_to || rel_to) ? 1 : 0;
    end
    e.mode    = model_mode;
    e.timeout = model_timeout;
    sb.push_back(e);

    mode_req    = 1'b1;
    mode_sel    = 2'(sel);
    frame_start = coincident;
    @(negedge clk);
    mode_req    = 1'b0;
    frame_start = 1'b0;
    mode_sel    = 2'($urandom_range(0, 3));

    if (!is_sw) begin
      check("same_ack", int'(mode_ack), 1);
      check("same_treset", int'(timing_reset), 0);
      check("same_blank", int'(blank), 0);
      check("same_mode", int'(mode), model_mode);
      @(negedge clk);
      check("same_ack_pulse", int'(mode_ack), 0);
      return;
    end

    check("accept_timeout_clr", int'(timeout), 0);
    check("accept_not_ready", int'(ready), 0);
    n = 0;
    while (timing_reset !== 1'b1 && n < BOUND) begin
      n++;
      frame_start = (n == wait_pulse);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("wait_len", n, wait_to ? TIMEOUT_CYCLES : wait_pulse);
    check("switch_mode", int'(mode), sel);
    check("switch_blank", int'(blank), 1);
    check("wait_timeout_flag", int'(timeout), wait_to ? 1 : 0);

    n = 0;
    while (timing_reset === 1'b1 && n < BOUND) begin
      n++;
      frame_start = inject && (n == 2);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("hold_len", n, RESET_CYCLES);

    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin
      n++;
      if (n == 1) check("release_blank", int'(blank), 1);
      frame_start = (n == rel_pulse);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("release_len", n, rel_to ? TIMEOUT_CYCLES : rel_pulse);
    check("done_ack", int'(mode_ack), 1);
    check("done_blank_off", int'(blank), 0);
    @(negedge clk);
    check("done_ack_pulse", int'(mode_ack), 0);
  endtask

  // Starts a switch to sel, then asserts reset while the generators are held.
  task automatic abort_switch(input int sel);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    mode_req = 1'b1;
    mode_sel = 2'(sel);
    @(negedge clk);
    mode_req = 1'b0;
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("abort_in_reset", int'(timing_reset), 1);
    check("abort_mode_before", int'(mode), sel);
    rst_n = 1'b0;
    #1;
    check("abort_mode_default", int'(mode), DEFAULT_MODE);
    check("abort_treset", int'(timing_reset), 1);
    check("abort_no_ack", int'(mode_ack), 0);
    check("abort_not_ready", int'(ready), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int sel, wp, rp;
    bit co, inj;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_treset", int'(timing_reset), 1);
    check("rst_blank", int'(blank), 1);
    check("rst_mode", int'(mode), DEFAULT_MODE);
    check("rst_ready", int'(ready), 0);
    check("rst_ack", int'(mode_ack), 0);
    check("rst_timeout", int'(timeout), 0);

    do_boot(2);
    do_request(0, 0, 0, 1'b0, 1'b0);   // same mode
    do_request(2, 10, 3, 1'b0, 1'b0);  // normal switch
    do_request(1, 0, 0, 1'b0, 1'b0);   // watchdog in both phases
    do_request(1, 0, 0, 1'b0, 1'b0);   // same mode keeps the sticky flag
    do_request(3, 5, 2, 1'b0, 1'b0);   // clears the flag
    do_request(0, 7, 4, 1'b1, 1'b1);   // coincident frame start, pulse during hold
    do_request(1, 1, 1, 1'b0, 1'b0);   // earliest pulses

    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 3);
      wp  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
      rp  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 10);
      co  = 1'($urandom_range(0, 1));
      inj = 1'($urandom_range(0, 1));
      do_request(sel, wp, rp, co, inj);
    end

    if (model_mode == 3) do_request(0, 2, 2, 1'b0, 1'b0);
    abort_switch(3);
    do_boot(3);
    do_request(2, 4, 4, 1'b0, 1'b0);

    @(negedge clk);
    check("blank_invariant", blank_bad, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/video_mode_ctrl.md
VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4: number of valid modes (1..4).
REQ-002 SHALL have parameter DEFAULT_MODE, default 0: mode selected after reset.
REQ-003 SHALL have parameter RESET_CYCLES, default 16: timing-generator reset hold length in clocks (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2097152: frame-start watchdog limit in clocks (>=2, <=2^24).
REQ-005 SHALL have port i_pixel_clk, input, 1: the only clock.
REQ-006 SHALL have port i_reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_mode_req, input, 1: mode change request valid.
REQ-008 SHALL have port i_mode_sel, input, 2: requested mode, qualified by i_mode_req.
REQ-009 SHALL have port o_ready, output, 1: request accepted on a clock where i_mode_req && o_ready.
REQ-010 SHALL have port o_mode_ack, output, 1: one-clock pulse on completion of an accepted request.
REQ-011 SHALL have port i_frame_start, input, 1: frame-start pulse from the timing generator.
REQ-012 SHALL have port o_timing_reset, output, 1: active-high reset to all timing generators.
REQ-013 SHALL have port o_mode, output, 2: mode select driving timing-generator muxes.
REQ-014 SHALL have port o_blank, output, 1: forces video output blank during a switch.
REQ-015 SHALL have port o_timeout, output, 1: sticky watchdog flag.

Function
REQ-016 SHALL implement states IDLE, WAIT_FRAME, RESET, RELEASE; o_ready=1 only in IDLE.
REQ-017 SHALL, on acceptance with valid i_mode_sel != o_mode, latch i_mode_sel, clear o_timeout, enter WAIT_FRAME next clock.
REQ-018 SHALL, on acceptance with i_mode_sel == o_mode or i_mode_sel >= NUM_MODES, stay IDLE, leave o_mode unchanged, pulse o_mode_ack the next clock.
REQ-019 SHALL ignore i_frame_start in the acceptance clock; WAIT_FRAME waits for a later pulse.
REQ-020 SHALL, on i_frame_start in WAIT_FRAME, enter RESET next clock with o_timing_reset=1, o_blank=1, o_mode=latched mode at that same edge.
REQ-021 SHALL hold RESET for exactly RESET_CYCLES clocks, then enter RELEASE with o_timing_reset=0, o_blank=1.
REQ-022 SHALL ignore i_frame_start while o_timing_reset=1.
REQ-023 SHALL, on i_frame_start in RELEASE, enter IDLE next clock with o_blank=0 and o_mode_ack=1 for exactly that one clock.
REQ-024 SHALL run a 24-bit watchdog counter, cleared on entering WAIT_FRAME or RELEASE.
REQ-025 SHALL, when the counter reaches TIMEOUT_CYCLES-1 in WAIT_FRAME without i_frame_start, set o_timeout and proceed to RESET as in REQ-020.
REQ-026 SHALL, when the counter reaches TIMEOUT_CYCLES-1 in RELEASE without i_frame_start, set o_timeout and complete as in REQ-023.
REQ-027 SHALL keep o_timeout set until reset or the next accepted switch (REQ-017).
REQ-028 SHALL ignore i_mode_req while o_ready=0; the requester holds i_mode_req and i_mode_sel until accepted.
REQ-029 SHALL drive o_blank=1 whenever o_timing_reset=1.

Reset
REQ-030 SHALL, while i_reset_n=0 and regardless of clock, force state RESET, o_timing_reset=1, o_blank=1, o_mode=DEFAULT_MODE, o_ready=0, o_mode_ack=0, o_timeout=0, counters 0.
REQ-031 SHALL, after i_reset_n deasserts, run the REQ-021/REQ-023 sequence but suppress o_mode_ack on reaching IDLE.
REQ-032 SHALL abandon any in-flight switch on reset without an o_mode_ack pulse.

Verification
REQ-033 SHALL cover reset release: RESET_CYCLES=4, i_reset_n rising, i_frame_start pulsed 2 clocks after RELEASE entry -> o_timing_reset high 4 clocks, IDLE reached, o_mode=0, no o_mode_ack.
REQ-034 SHALL cover a normal switch: request mode 2, i_frame_start 10 clocks later -> o_mode=2 and o_timing_reset=1 one clock after that pulse, held 4 clocks, o_mode_ack single pulse after the next frame start.
REQ-035 SHALL cover a same-mode request: request mode equal to o_mode -> o_mode_ack the next clock, o_timing_reset stays 0, o_blank stays 0.
REQ-036 SHALL cover the watchdog: TIMEOUT_CYCLES=64, no i_frame_start -> RESET entered 64 clocks after WAIT_FRAME entry, o_timeout=1, ack after a further 64 clocks in RELEASE, o_timeout cleared on the next accepted switch.
REQ-037 SHALL cover a coincident frame start: i_frame_start asserted in the acceptance clock -> no transition to RESET until the next pulse.
REQ-038 SHALL cover mid-switch reset: i_reset_n asserted in RESET of a switch to mode 3 -> o_mode=DEFAULT_MODE immediately, no o_mode_ack.
